// File: rtl/sticky_event_collector_pkg.sv
// Shared types and constants for the sticky event collector and its
// saturating coalesce counter.
package sticky_event_collector_pkg;

   localparam int unsigned EVENT_WIDTH = 8;
   localparam int unsigned COUNT_WIDTH = 8;

   // Bit positions inside the clock/reset bundle
   localparam int unsigned CLK_BIT = 0;
   localparam int unsigned RST_BIT = 1;

   typedef logic [1:0] clock_reset_t;

   typedef struct packed {
      logic                   valid;
      logic [EVENT_WIDTH-1:0] data;
   } snapshot_t;

   function automatic logic clock_of(input clock_reset_t cr);
      return cr[CLK_BIT];
   endfunction

   function automatic logic reset_of(input clock_reset_t cr);
      return cr[RST_BIT];
   endfunction

endpackage

// File: rtl/sticky_event_collector_sat_counter.sv
// Saturating up-counter; clear wins over the old value, then a same-cycle
// increment is applied on top of the cleared value.
module sat_counter
   import sticky_event_collector_pkg::*;
#(
   parameter int unsigned CNT_W = COUNT_WIDTH
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   input  logic             clr,
   output logic [CNT_W-1:0] value
);

   localparam logic [CNT_W-1:0] MAX_VALUE = '1;

   logic [CNT_W-1:0] value_q;
   logic [CNT_W-1:0] value_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         value_q <= '0;
      end else begin
         value_q <= value_d;
      end
   end

   always_comb begin
      value_d = value_q;
      if (clr) begin
         value_d = CNT_W'(inc);
      end else if (inc && (value_q != MAX_VALUE)) begin
         value_d = value_q + CNT_W'(1);
      end
   end

   assign value = value_q;

endmodule

// File: rtl/sticky_event_collector.sv
// Collects event pulses into sticky flags and hands them out as
// read-to-clear snapshots over a valid/ready handshake.
module sticky_event_collector
   import sticky_event_collector_pkg::*;
#(
   parameter int unsigned WIDTH = EVENT_WIDTH,
   parameter int unsigned CNT_W = COUNT_WIDTH
) (
   input  clock_reset_t     clock_reset,
   input  logic [WIDTH-1:0] events,
   input  logic             snap_ready,
   input  logic             clear_count,
   output logic             snap_valid,
   output logic [WIDTH-1:0] snap_data,
   output logic [WIDTH-1:0] flags,
   output logic             any,
   output logic [CNT_W-1:0] coalesced
);

   logic clk;
   logic rst;

   assign clk = clock_of(clock_reset);
   assign rst = reset_of(clock_reset);

   logic [WIDTH-1:0] flags_q;
   logic [WIDTH-1:0] flags_d;
   logic             snap_valid_q;
   logic             snap_valid_d;
   logic [WIDTH-1:0] snap_data_q;
   logic [WIDTH-1:0] snap_data_d;

   logic slot_free_c;
   logic capture_c;
   logic coal_c;

   assign slot_free_c = !snap_valid_q || snap_ready;
   assign capture_c   = slot_free_c && (flags_q != '0);
   // An event is only lost when its flag is still pending after this edge
   assign coal_c      = (|(events & flags_q)) && !capture_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q      <= '0;
         snap_valid_q <= 1'b0;
         snap_data_q  <= '0;
      end else begin
         flags_q      <= flags_d;
         snap_valid_q <= snap_valid_d;
         snap_data_q  <= snap_data_d;
      end
   end

   always_comb begin
      flags_d      = flags_q | events;
      snap_valid_d = snap_valid_q;
      snap_data_d  = snap_data_q;
      if (capture_c) begin
         // Prior flags move to the snapshot; same-cycle events start fresh
         flags_d      = events;
         snap_valid_d = 1'b1;
         snap_data_d  = flags_q;
      end else if (snap_valid_q && snap_ready) begin
         snap_valid_d = 1'b0;
      end
   end

   sat_counter #(
      .CNT_W (CNT_W)
   ) u_coal_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (coal_c),
      .clr   (clear_count),
      .value (coalesced)
   );

   assign flags      = flags_q;
   assign any        = |flags_q;
   assign snap_valid = snap_valid_q;
   assign snap_data  = snap_data_q;

   // Handshake: a stalled snapshot must not move or vanish
   a_snap_hold: assert property (@(posedge clk) disable iff (rst)
      (snap_valid_q && !snap_ready) |=> (snap_valid_q && $stable(snap_data_q)));

endmodule

// File: tb/tb_sticky_event_collector.sv
// Table-driven bench with a scoreboard queue for sticky_event_collector.
module tb_sticky_event_collector;
   import sticky_event_collector_pkg::*;

   localparam int unsigned W = EVENT_WIDTH;
   localparam int unsigned C = COUNT_WIDTH;

   typedef struct {
      logic         rst;
      logic [W-1:0] ev;
      logic         rdy;
      logic         clr;
      logic [W-1:0] flags;
      logic         valid;
      logic [W-1:0] data;
      logic [C-1:0] coal;
   } vec_t;

   typedef struct {
      string        name;
      snapshot_t    snap;
      logic [W-1:0] flags;
      logic [C-1:0] coal;
   } exp_t;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic [W-1:0] events = '0;
   logic         snap_ready = 1'b0;
   logic         clear_count = 1'b0;
   logic         snap_valid;
   logic [W-1:0] snap_data;
   logic [W-1:0] flags;
   logic         any;
   logic [C-1:0] coalesced;
   clock_reset_t clock_reset;

   int n_checks = 0;
   int n_fail   = 0;
   exp_t sb_q[$];
   vec_t tbl[20];

   assign clock_reset = {rst, clk};

   always #5 clk = ~clk;

   sticky_event_collector #(
      .WIDTH (W),
      .CNT_W (C)
   ) dut (
      .clock_reset (clock_reset),
      .events      (events),
      .snap_ready  (snap_ready),
      .clear_count (clear_count),
      .snap_valid  (snap_valid),
      .snap_data   (snap_data),
      .flags       (flags),
      .any         (any),
      .coalesced   (coalesced)
   );

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   // Drive one cycle, queue the expectation, compare after the edge
   task automatic step(input string name, input logic r, input logic [W-1:0] ev,
                       input logic rd, input logic cl, input logic [W-1:0] ef,
                       input logic ev_valid, input logic [W-1:0] ed,
                       input logic [C-1:0] ec);
      exp_t e;
      exp_t got;
      rst = r; events = ev; snap_ready = rd; clear_count = cl;
      e.name = name;
      e.snap.valid = ev_valid;
      e.snap.data  = ed;
      e.flags = ef;
      e.coal  = ec;
      sb_q.push_back(e);
      @(posedge clk);
      #1;
      if (sb_q.size() == 0) begin
         n_checks++;
         n_fail++;
         $display("FAIL %s: scoreboard empty", name);
      end else begin
         got = sb_q.pop_front();
         check({got.name, ".flags"}, int'(flags), int'(got.flags));
         check({got.name, ".any"}, int'(any), int'(got.flags != '0));
         check({got.name, ".snap_valid"}, int'(snap_valid), int'(got.snap.valid));
         check({got.name, ".snap_data"}, int'(snap_data), int'(got.snap.data));
         check({got.name, ".coalesced"}, int'(coalesced), int'(got.coal));
      end
   endtask

   task automatic run_vec(input int i);
      step($sformatf("vec%0d", i), tbl[i].rst, tbl[i].ev, tbl[i].rdy, tbl[i].clr,
           tbl[i].flags, tbl[i].valid, tbl[i].data, tbl[i].coal);
   endtask

   initial begin
      //          rst   ev     rdy   clr   flags  valid data   coal
      tbl[0]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'd0};
      tbl[1]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 8'h00, 1'b0, 8'h00, 8'd0};
      tbl[2]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'd0};
      tbl[3]  = '{1'b0, 8'h05, 1'b1, 1'b0, 8'h05, 1'b0, 8'h00, 8'd0};
      tbl[4]  = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b1, 8'h05, 8'd0};
      tbl[5]  = '{1'b0, 8'h03, 1'b0, 1'b0, 8'h03, 1'b1, 8'h05, 8'd0};
      tbl[6]  = '{1'b0, 8'h02, 1'b0, 1'b0, 8'h03, 1'b1, 8'h05, 8'd1};
      tbl[7]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 8'h03, 8'd1};
      tbl[8]  = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h03, 8'd1};
      tbl[9]  = '{1'b0, 8'h01, 1'b0, 1'b0, 8'h01, 1'b0, 8'h03, 8'd1};
      tbl[10] = '{1'b0, 8'h01, 1'b0, 1'b0, 8'h01, 1'b1, 8'h01, 8'd1};
      // continues after the saturation sequence (coal cleared to 0)
      tbl[11] = '{1'b0, 8'h80, 1'b1, 1'b0, 8'h80, 1'b1, 8'h01, 8'd0};
      tbl[12] = '{1'b0, 8'h10, 1'b1, 1'b0, 8'h10, 1'b1, 8'h80, 8'd0};
      tbl[13] = '{1'b0, 8'h00, 1'b0, 1'b0, 8'h10, 1'b1, 8'h80, 8'd0};
      tbl[14] = '{1'b1, 8'hFF, 1'b1, 1'b0, 8'h00, 1'b0, 8'h00, 8'd0};
      tbl[15] = '{1'b0, 8'h11, 1'b1, 1'b0, 8'h11, 1'b0, 8'h00, 8'd0};
      tbl[16] = '{1'b0, 8'h22, 1'b1, 1'b0, 8'h22, 1'b1, 8'h11, 8'd0};
      tbl[17] = '{1'b0, 8'h44, 1'b1, 1'b0, 8'h44, 1'b1, 8'h22, 8'd0};
      tbl[18] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b1, 8'h44, 8'd0};
      tbl[19] = '{1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 8'h44, 8'd0};

      for (int i = 0; i <= 10; i++) run_vec(i);

      // Stalled snapshot 0x01, flag 0x01 pending: every event coalesces
      for (int k = 1; k <= 300; k++) begin
         step($sformatf("sat%0d", k), 1'b0, 8'h01, 1'b0, 1'b0, 8'h01, 1'b1, 8'h01,
              (k + 1 >= 255) ? 8'd255 : 8'(k + 1));
      end
      step("clr_with_coal", 1'b0, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 8'h01, 8'd1);
      step("clr_alone", 1'b0, 8'h00, 1'b0, 1'b1, 8'h01, 1'b1, 8'h01, 8'd0);

      for (int i = 11; i <= 19; i++) run_vec(i);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not complete, checks=%0d", n_checks);
      $fatal(1);
   end

endmodule
